// File: rtl/data_rate_decoder_if.sv
// Handshake-free receive bus of the toggle-rate decoder: line-side inputs and decoded-word outputs.
interface data_rate_decoder_if #(
  parameter int NUM_BITS = 10
);
  logic                enable;
  logic                rx_in;
  logic [NUM_BITS-1:0] data_out;
  logic                data_valid;
  logic                word_err;
  logic                locked;
  logic [7:0]          err_count;

  modport master (
    output enable, rx_in,
    input  data_out, data_valid, word_err, locked, err_count
  );

  modport slave (
    input  enable, rx_in,
    output data_out, data_valid, word_err, locked, err_count
  );
endinterface

// File: rtl/data_rate_decoder.sv
// Toggle-rate word decoder: preamble hunt, then fixed-length bit windows judged by transition count.
// Latency 4 clocks of pipeline after the last window sample; no backpressure, words repeat back-to-back.
module data_rate_decoder #(
  parameter int PRE_LEN  = 48,
  parameter int BIT_LEN  = 33,
  parameter int NUM_BITS = 10,
  parameter int LOW_MAX  = 4,
  parameter int HIGH_MIN = 29
) (
  input logic               clock,
  input logic               reset,
  data_rate_decoder_if.slave bus
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] WIN_LAST  = 6'(BIT_LEN - 1);
  localparam logic [5:0] HALF_C    = 6'(BIT_LEN / 2);
  localparam logic [5:0] LOW_C     = 6'(LOW_MAX);
  localparam logic [5:0] HIGH_C    = 6'(HIGH_MIN);
  localparam logic [3:0] BITS_LAST = 4'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

  state_t              state_q, state_d;
  logic                en_s1_q, en_s_q, rx_s1_q, rx_s_q;
  logic                rx_prev_q, rx_prev_d, tr_q;
  logic [5:0]          run_cnt_q, run_cnt_d;
  logic [5:0]          win_cnt_q, win_cnt_d;
  logic [5:0]          tcnt_q, tcnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic                err_acc_q, err_acc_d;
  logic                done_q, done_d;
  logic                err_word_q, err_word_d;
  logic [NUM_BITS-1:0] data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                word_err_q, word_err_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [5:0] tcnt_fin;
  logic       bit_val;
  logic       amb;

  // The final sample of a window must include the transition seen on that same clock.
  assign tcnt_fin = tcnt_q + {5'd0, tr_q};
  assign bit_val  = (tcnt_fin > HALF_C);
  assign amb      = (tcnt_fin > LOW_C) && (tcnt_fin < HIGH_C);

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    win_cnt_d    = win_cnt_q;
    tcnt_d       = tcnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    err_acc_d    = err_acc_q;
    done_d       = 1'b0;
    err_word_d   = err_word_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    word_err_d   = word_err_q;
    err_count_d  = err_count_q;

    // Publish a completed word one clock after its last sample.
    if (done_q) begin
      data_out_d   = shreg_q;
      word_err_d   = err_word_q;
      data_valid_d = 1'b1;
      if (err_word_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    if (!en_s_q) begin
      state_d   = IDLE;
      run_cnt_d = '0;
      win_cnt_d = '0;
      tcnt_d    = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
      err_acc_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (tr_q) begin
            if (run_cnt_q == PRE_LAST) begin
              state_d   = DATA;
              run_cnt_d = '0;
              win_cnt_d = '0;
              tcnt_d    = '0;
              bit_cnt_d = '0;
              err_acc_d = 1'b0;
            end else begin
              run_cnt_d = run_cnt_q + 6'd1;
            end
          end else begin
            run_cnt_d = '0;
          end
        end
        DATA: begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            tcnt_d    = '0;
            shreg_d   = {shreg_q[NUM_BITS-2:0], bit_val};
            if (bit_cnt_q == BITS_LAST) begin
              bit_cnt_d  = '0;
              err_acc_d  = 1'b0;
              err_word_d = err_acc_q | amb;
              done_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              err_acc_d = err_acc_q | amb;
            end
          end else begin
            win_cnt_d = win_cnt_q + 6'd1;
            tcnt_d    = tcnt_fin;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The modulator idles low, so the first toggle out of IDLE must register as a transition.
    rx_prev_d = (state_d == IDLE) ? 1'b0 : rx_s_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      en_s1_q      <= 1'b0;
      en_s_q       <= 1'b0;
      rx_s1_q      <= 1'b0;
      rx_s_q       <= 1'b0;
      rx_prev_q    <= 1'b0;
      tr_q         <= 1'b0;
      run_cnt_q    <= '0;
      win_cnt_q    <= '0;
      tcnt_q       <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      err_acc_q    <= 1'b0;
      done_q       <= 1'b0;
      err_word_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      word_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      en_s1_q      <= bus.enable;
      en_s_q       <= en_s1_q;
      rx_s1_q      <= bus.rx_in;
      rx_s_q       <= rx_s1_q;
      rx_prev_q    <= rx_prev_d;
      tr_q         <= rx_s_q ^ rx_prev_q;
      run_cnt_q    <= run_cnt_d;
      win_cnt_q    <= win_cnt_d;
      tcnt_q       <= tcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      err_acc_q    <= err_acc_d;
      done_q       <= done_d;
      err_word_q   <= err_word_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      word_err_q   <= word_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.word_err   = word_err_q;
  assign bus.locked     = (state_q == DATA);
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_data_rate_decoder.sv
// Bench for data_rate_decoder: table of frames scored through an expected-word queue, plus
// hand-driven glitch, enable-drop, mid-frame reset and error-counter saturation sequences.
module tb_data_rate_decoder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_rate_decoder_if #(.NUM_BITS(10)) bus ();
  data_rate_decoder_if #(.NUM_BITS(2))  sbus ();

  data_rate_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Scaled-down instance so the 8-bit error counter can be driven past 255 in few clocks.
  data_rate_decoder #(
    .PRE_LEN(8), .BIT_LEN(9), .NUM_BITS(2), .LOW_MAX(1), .HIGH_MIN(8)
  ) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (sbus)
  );

  typedef struct {
    logic [9:0] word;
    logic       err;
    logic [7:0] errcnt;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [9:0] word;
    int         nwords;
    int         inj_bit;
    int         inj_cnt;
    logic [9:0] exp_first;
    logic       exp_err;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[12];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         model_errcnt = 0;
  logic [9:0] last_word = '0;
  int         sat_words = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  always @(negedge clock) begin
    if (bus.data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", 32'(bus.data_out), 32'(mon_e.word));
        check("word_err", 32'(bus.word_err), 32'(mon_e.err));
        check("err_count", 32'(bus.err_count), 32'(mon_e.errcnt));
        check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    if (sbus.data_valid === 1'b1) begin
      sat_words++;
      if (sat_words == 1)   check("sat_first", 32'(sbus.err_count), 32'd1);
      if (sat_words == 255) check("sat_255", 32'(sbus.err_count), 32'd255);
      if (sat_words == 256) check("sat_nowrap", 32'(sbus.err_count), 32'd255);
      if (sat_words == 300) check("sat_300", 32'(sbus.err_count), 32'd255);
    end
  end

  task automatic send_frame(input logic [9:0] word, input int nwords, input int inj_bit,
                            input int inj_cnt, input logic [9:0] exp_first,
                            input logic exp_err, input bit glitch, input int stop_bit);
    logic plan[$];
    exp_t e;
    int   c0;
    int   cnt;
    bit   stopped;
    stopped = 0;
    for (int p = 0; p < 48; p++) begin
      if (glitch && p == 20) plan.push_back(1'b0);
      plan.push_back(1'b1);
    end
    for (int w = 0; w < nwords && !stopped; w++) begin
      for (int b = 0; b < 10 && !stopped; b++) begin
        if (w == 0 && b == stop_bit) begin
          stopped = 1;
        end else begin
          cnt = word[9-b] ? 33 : ((w == 0 && b == inj_bit) ? inj_cnt : 0);
          for (int i = 0; i < 33; i++) plan.push_back(i < cnt);
        end
      end
    end
    @(negedge clock);
    c0 = cyc;
    if (!glitch && stop_bit < 0) begin
      for (int w = 0; w < nwords; w++) begin
        e.word = (w == 0) ? exp_first : word;
        e.err  = (w == 0) ? exp_err : 1'b0;
        if (e.err && model_errcnt < 255) model_errcnt++;
        e.errcnt = 8'(model_errcnt);
        e.cyc  = c0 + 382 + 330 * w;
        last_word = e.word;
        sb.push_back(e);
      end
    end
    bus.enable = 1'b1;
    for (int k = 0; k < plan.size(); k++) begin
      if (k > 0) @(negedge clock);
      if (k == 50) check("locked_pre48", 32'(bus.locked), 32'd0);
      if (k == 51) check("locked_at48", 32'(bus.locked), glitch ? 32'd0 : 32'd1);
      if (plan[k]) bus.rx_in = ~bus.rx_in;
    end
    if (stop_bit >= 0) begin
      @(negedge clock);
      bus.enable = 1'b0;
      bus.rx_in  = 1'b0;
      @(negedge clock);
      check("drop_locked_d1", 32'(bus.locked), 32'd1);
      repeat (2) @(negedge clock);
      check("drop_locked_d3", 32'(bus.locked), 32'd0);
      check("drop_data_hold", 32'(bus.data_out), 32'(last_word));
      check("drop_errcnt_hold", 32'(bus.err_count), 32'(model_errcnt));
    end else begin
      repeat (8) @(negedge clock);
      bus.enable = 1'b0;
      bus.rx_in  = 1'b0;
    end
    repeat (8) @(negedge clock);
  endtask

  initial begin
    vecs[0]  = '{10'h2A5, 3, -1, 0,  10'h2A5, 1'b0};
    vecs[1]  = '{10'h3FF, 2, -1, 0,  10'h3FF, 1'b0};
    vecs[2]  = '{10'h000, 2, -1, 0,  10'h000, 1'b0};
    vecs[3]  = '{10'h000, 1,  3, 12, 10'h000, 1'b1};
    vecs[4]  = '{10'h000, 1,  3, 20, 10'h040, 1'b1};
    vecs[5]  = '{10'h2A5, 1,  1, 4,  10'h2A5, 1'b0};
    vecs[6]  = '{10'h2A5, 1,  1, 5,  10'h2A5, 1'b1};
    vecs[7]  = '{10'h000, 1,  0, 29, 10'h200, 1'b0};
    vecs[8]  = '{10'h000, 1,  0, 28, 10'h200, 1'b1};
    vecs[9]  = '{10'h000, 1,  9, 16, 10'h000, 1'b1};
    vecs[10] = '{10'h000, 1,  9, 17, 10'h001, 1'b1};
    vecs[11] = '{10'h1C3, 2, -1, 0,  10'h1C3, 1'b0};

    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.rx_in   = 1'b0;
    sbus.enable = 1'b0;
    sbus.rx_in  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_word_err", 32'(bus.word_err), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int v = 0; v < 12; v++) begin
      send_frame(vecs[v].word, vecs[v].nwords, vecs[v].inj_bit, vecs[v].inj_cnt,
                 vecs[v].exp_first, vecs[v].exp_err, 1'b0, -1);
    end

    // Preamble glitch: no lock and no word for that frame, then a clean retrigger.
    send_frame(10'h155, 2, -1, 0, 10'h155, 1'b0, 1'b1, -1);
    send_frame(10'h155, 2, -1, 0, 10'h155, 1'b0, 1'b0, -1);

    // Enable dropped at bit 6 of the first word.
    send_frame(10'h2A5, 1, -1, 0, 10'h2A5, 1'b0, 1'b0, 6);

    // Reset in the middle of a data window.
    @(negedge clock);
    bus.enable = 1'b1;
    for (int k = 0; k < 148; k++) begin
      if (k > 0) @(negedge clock);
      bus.rx_in = ~bus.rx_in;
    end
    @(negedge clock);
    check("mid_locked", 32'(bus.locked), 32'd1);
    check("mid_data_before", 32'(bus.data_out), 32'(last_word));
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
    check("mid_rst_word_err", 32'(bus.word_err), 32'd0);
    check("mid_rst_locked", 32'(bus.locked), 32'd0);
    check("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.rx_in  = 1'b0;
    model_errcnt = 0;
    last_word    = '0;
    repeat (8) @(negedge clock);

    // 300 ambiguous words on the scaled instance: 4 toggles in every 9-clock window.
    @(negedge clock);
    sbus.enable = 1'b1;
    for (int p = 0; p < 8; p++) begin
      if (p > 0) @(negedge clock);
      sbus.rx_in = ~sbus.rx_in;
    end
    for (int w = 0; w < 300; w++) begin
      for (int i = 0; i < 18; i++) begin
        @(negedge clock);
        if ((i % 9) < 4) sbus.rx_in = ~sbus.rx_in;
      end
    end
    repeat (8) @(negedge clock);
    sbus.enable = 1'b0;
    sbus.rx_in  = 1'b0;
    repeat (8) @(negedge clock);

    check("sat_words", 32'(sat_words), 32'd300);
    check("sat_final", 32'(sbus.err_count), 32'd255);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
